freq_meter: RTL and testbench

Gated-window frequency meter. It counts rising edges of an asynchronous external square wave, such as the water-sensor oscillator or a divided clock, over a fixed number of system-clock cycles. It reports the count as a registered result with a one-cycle completion pulse. It sits between the sensor input pin and the detection/display logic, on the same 10 MHz system clock as the clock dividers.

---
 rtl/freq_meter_pkg.sv | 22 ++
 rtl/sync_edge.sv | 37 +++
 rtl/freq_meter.sv | 124 ++++++++++++
 tb/tb_freq_meter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : freq_meter_pkg                                     |
// | Description : Shared state encoding and default sizing for the   |
// |               gated-window frequency meter.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package freq_meter_pkg;

  // Default window: 1 s at a 10 MHz system clock
  localparam int unsigned c_def_gate_cycles = 10_000_000;
  localparam int unsigned c_def_cnt_w       = 24;

  // Measurement FSM encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage : freq_meter_pkg
`default_nettype wire

// File: rtl/sync_edge.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : sync_edge                                          |
// | Description : Two-flop synchronizer for an asynchronous pin plus |
// |               a history flop giving a one-cycle rising-edge      |
// |               pulse in the clk_in domain.                        |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module sync_edge (
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_async,
  output logic edge_p
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer chain; flops clear on reset so a pin already high
  // at reset release shows up as one edge.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= sig_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign edge_p = r_s2 & ~r_s3;

endmodule : sync_edge
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : freq_meter                                         |
// | Description : Counts rising edges of an asynchronous input over  |
// |               a fixed window of GATE_CYCLES clocks and reports   |
// |               the saturating count with a one-cycle done pulse.  |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = c_def_gate_cycles,
  parameter int unsigned CNT_W       = c_def_cnt_w,
  parameter bit          CONTINUOUS  = 1'b0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] freq,
  output logic             overflow
);

  localparam int unsigned           c_gcnt_w    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [c_gcnt_w-1:0]   c_gate_last = c_gcnt_w'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]      c_cnt_max   = '1;

  logic                w_edge_p;
  logic [CNT_W-1:0]    w_ecnt_next;
  logic                w_sat_next;

  state_t              r_state;
  logic [c_gcnt_w-1:0] r_gcnt;
  logic [CNT_W-1:0]    r_ecnt;
  logic                r_sat;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_freq;
  logic                r_overflow;

  sync_edge u_sync_edge (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .sig_async (sig_in),
    .edge_p    (w_edge_p)
  );

  // Saturating edge count including the current cycle's edge, so the
  // last gate cycle's edge lands in the latched result.
  always_comb begin
    w_ecnt_next = r_ecnt;
    w_sat_next  = r_sat;
    if (w_edge_p) begin
      if (r_ecnt == c_cnt_max) begin
        w_sat_next = 1'b1;
      end else begin
        w_ecnt_next = r_ecnt + CNT_W'(1);
      end
    end
  end

  // Measurement FSM with registered status and result outputs
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_gcnt     <= '0;
      r_ecnt     <= '0;
      r_sat      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_freq     <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start || CONTINUOUS) begin
            r_state <= ST_GATE;
            r_busy  <= 1'b1;
            r_gcnt  <= '0;
            r_ecnt  <= '0;
            r_sat   <= 1'b0;
          end
        end
        ST_GATE: begin
          r_ecnt <= w_ecnt_next;
          r_sat  <= w_sat_next;
          r_gcnt <= r_gcnt + c_gcnt_w'(1);
          if (r_gcnt == c_gate_last) begin
            r_state    <= ST_DONE;
            r_freq     <= w_ecnt_next;
            r_overflow <= w_sat_next;
            r_done     <= 1'b1;
          end
        end
        ST_DONE: begin
          // Edges during this cycle are dropped: one dead cycle per window
          if (CONTINUOUS) begin
            r_state <= ST_GATE;
            r_gcnt  <= '0;
            r_ecnt  <= '0;
            r_sat   <= 1'b0;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign freq     = r_freq;
  assign overflow = r_overflow;

endmodule : freq_meter
`default_nettype wire

// File: tb/tb_freq_meter.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------+
// | Module      : tb_freq_meter                                      |
// | Description : Scoreboard bench for freq_meter: one single-shot   |
// |               instance and one continuous instance driven from   |
// |               per-cycle waveform tables.                         |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_freq_meter;

  localparam int GA = 100;
  localparam int WA = 4;
  localparam int GB = 50;
  localparam int WB = 8;
  localparam int NW = 4096;
  localparam int NB_WIN = 7;

  typedef struct {
    int t;
    int f;
    bit o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_a_n, rst_b_n;
  logic          sig_a, sig_b;
  logic          start_a, start_b;
  logic          busy_a, done_a, overflow_a;
  logic          busy_b, done_b, overflow_b;
  logic [WA-1:0] freq_a;
  logic [WB-1:0] freq_b;

  int   cyc = 0;
  bit   wave_a [NW];
  bit   wave_b [NW];
  exp_t sb_a[$];
  exp_t sb_b[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  freq_meter #(.GATE_CYCLES(GA), .CNT_W(WA), .CONTINUOUS(1'b0)) u_a (
    .clk_in(clk), .rst_n(rst_a_n), .sig_in(sig_a), .start(start_a),
    .busy(busy_a), .done(done_a), .freq(freq_a), .overflow(overflow_a)
  );

  freq_meter #(.GATE_CYCLES(GB), .CNT_W(WB), .CONTINUOUS(1'b1)) u_b (
    .clk_in(clk), .rst_n(rst_b_n), .sig_in(sig_b), .start(start_b),
    .busy(busy_b), .done(done_b), .freq(freq_b), .overflow(overflow_b)
  );

  // cyc = number of rising clock edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // wave_x[k] is the sig value sampled at rising edge number k
  always @(negedge clk) begin
    if (cyc + 1 < NW) begin
      sig_a = wave_a[cyc + 1];
      sig_b = wave_b[cyc + 1];
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference: a rise first sampled at edge j is counted at edge j+2,
  // so a window whose start is accepted at edge p counts rises with
  // j in [p-1, p+g-2]; the result then saturates at 2^W-1.
  function automatic int rises(input bit use_b, input int p, input int g);
    int n = 0;
    for (int j = p - 1; j <= p + g - 2; j++) begin
      if (use_b) begin
        if (wave_b[j] && !wave_b[j-1]) n++;
      end else begin
        if (wave_a[j] && !wave_a[j-1]) n++;
      end
    end
    return n;
  endfunction

  function automatic exp_t make_exp(input int t, input int raw, input int w);
    exp_t e;
    int   mx = (1 << w) - 1;
    e.t = t;
    e.f = (raw > mx) ? mx : raw;
    e.o = (raw > mx);
    return e;
  endfunction

  task automatic fill_a(input int from, input int len, input int period, input int phase);
    for (int i = 0; i < len; i++) begin
      if (from + i < NW) wave_a[from + i] = (((i + phase) % period) < (period / 2));
    end
  endtask

  // One single-shot measurement; optionally a second start mid-gate
  task automatic run_a(input int period, input bit extra_start);
    int   p;
    int   k;
    exp_t e;
    fill_a(cyc + 3, GA + 40, period, $urandom_range(0, period - 1));
    @(negedge clk);
    start_a = 1'b1;
    p = cyc + 1;
    e = make_exp(p + GA, rises(1'b0, p, GA), WA);
    sb_a.push_back(e);
    @(negedge clk);
    start_a = 1'b0;
    check("a_busy_on", busy_a, 1);
    if (extra_start) begin
      repeat (50) @(negedge clk);
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
    end
    k = 0;
    while (sb_a.size() != 0 && k < GA + 20) begin
      @(negedge clk);
      k++;
    end
    if (sb_a.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL a_done_timeout: got no done expected done at cycle %0d", e.t);
      sb_a.delete();
    end
    @(negedge clk);
    check("a_busy_off", busy_a, 0);
    check("a_freq_hold", freq_a, e.f);
    repeat (3) @(negedge clk);
  endtask

  // Scoreboard monitor, single-shot instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_a_n === 1'b1 && done_a === 1'b1) begin
        if (sb_a.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL a_unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb_a.pop_front();
          check("a_done_time", cyc, e.t);
          check("a_freq", freq_a, e.f);
          check("a_overflow", overflow_a, e.o);
        end
      end
    end
  end

  // Scoreboard monitor, continuous instance
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_b_n === 1'b1 && done_b === 1'b1) begin
        if (sb_b.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_unexpected_done: got done at cycle %0d expected none", cyc);
        end else begin
          e = sb_b.pop_front();
          check("b_done_time", cyc, e.t);
          check("b_freq", freq_b, e.f);
          check("b_overflow", overflow_b, e.o);
          check("b_busy", busy_b, 1);
        end
      end
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: got no end of test expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < NW; i++) begin
      wave_a[i] = 1'($urandom_range(0, 1));
      wave_b[i] = 1'b0;
    end
    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    sig_a   = 1'b0;
    sig_b   = 1'b0;

    fork
      // ---------------- single-shot instance ----------------
      begin
        repeat (4) begin
          @(negedge clk);
          check("a_rst_busy", busy_a, 0);
          check("a_rst_done", done_a, 0);
          check("a_rst_freq", freq_a, 0);
          check("a_rst_ovf", overflow_a, 0);
        end
        rst_a_n = 1'b1;
        repeat (60) @(negedge clk);
        check("a_idle_freq", freq_a, 0);
        check("a_idle_busy", busy_a, 0);

        run_a(10, 1'b0);
        run_a(4, 1'b0);
        run_a(30, 1'b0);
        run_a(7, 1'b1);

        // Abort a window 40 cycles in
        fill_a(cyc + 3, GA + 40, 6, 0);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (39) @(negedge clk);
        rst_a_n = 1'b0;
        #1;
        check("a_abort_busy", busy_a, 0);
        check("a_abort_freq", freq_a, 0);
        check("a_abort_ovf", overflow_a, 0);
        repeat (3) @(negedge clk);
        rst_a_n = 1'b1;
        repeat (GA + 10) @(negedge clk);

        run_a(10, 1'b0);
        repeat (3) run_a($urandom_range(2, 40), 1'b0);
      end

      // ---------------- continuous instance ----------------
      begin
        int   p0;
        int   sw;
        int   k;
        exp_t e;
        sw = 200 + $urandom_range(0, 60);
        for (int i = 0; i < NW; i++) begin
          if (i < sw) wave_b[i] = ((i % 5) < 2);
          else        wave_b[i] = (((i - sw) % 10) < 5);
        end
        repeat (10) @(negedge clk);
        check("b_rst_busy", busy_b, 0);
        rst_b_n = 1'b1;
        p0 = cyc + 1;
        for (int m = 0; m < NB_WIN; m++) begin
          e = make_exp(p0 + m * (GB + 1) + GB, rises(1'b1, p0 + m * (GB + 1), GB), WB);
          sb_b.push_back(e);
        end
        @(negedge clk);
        check("b_busy_start", busy_b, 1);
        k = 0;
        while (sb_b.size() != 0 && k < NB_WIN * (GB + 1) + 20) begin
          @(negedge clk);
          k++;
        end
        if (sb_b.size() != 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL b_done_timeout: got %0d windows pending expected 0", sb_b.size());
          sb_b.delete();
        end
        @(negedge clk);
        rst_b_n = 1'b0;
      end
    join

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_freq_meter
`default_nettype wire
